// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared types and geometry for the frame-buffer arbiter slice.
// Imported by the interface and the top-level arbiter.
package frame_buffer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 400;
  localparam int FRAME_PIXELS_640X400 = H_ACTIVE * V_ACTIVE;
  localparam int PIXEL_W_DEF = 4;

  typedef enum logic {
    RUN,
    SWAP_WAIT
  } swap_st_t;

  typedef enum logic [1:0] {
    SEL_READ,
    SEL_FIFO,
    SEL_CLEAR,
    SEL_IDLE
  } ram_sel_t;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Host pixel-write handshake bundle.
// master = host pixel writer, slave = arbiter.
interface frame_buffer_arbiter_if
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int PIXEL_W = PIXEL_W_DEF
);

  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PIXEL_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/frame_buffer_arbiter_fifo.sv
// Synchronous write FIFO for buffered host pixel writes.
// Pointers carry one extra wrap bit to tell full from empty.
module fb_write_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: display reads, buffered host writes,
// frame-aligned bank swap; optional back-bank clear via FRAME_BUFFER_CLEAR_EN.
module frame_buffer_arbiter
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int PIXEL_W      = PIXEL_W_DEF,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = FRAME_PIXELS_640X400,
  parameter int CLEAR_COLOR  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  frame_buffer_arbiter_if.slave wr,
  input  logic               swap_req,
  output logic               swap_pending,
  output logic               front_bank,
  input  logic               clear_req,
  output logic               clear_busy,
  input  logic               disp_frame_start,
  input  logic               disp_rd_en,
  input  logic [ADDR_W-1:0]  disp_rd_addr,
  output logic [PIXEL_W-1:0] disp_color,
  output logic               disp_color_valid,
  output logic [ADDR_W:0]    ram_addr,
  output logic               ram_we,
  output logic [PIXEL_W-1:0] ram_wdata,
  input  logic [PIXEL_W-1:0] ram_rdata
);

  localparam int FW = ADDR_W + PIXEL_W;

  swap_st_t           state;
  ram_sel_t           sel;
  logic               live;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [FW-1:0]      head;
  logic               rd_q1;
  logic               rd_q2;
  logic               clr_active;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [PIXEL_W-1:0] clr_data;

  // live keeps wr_ready low while reset is asserted
  assign wr.wr_ready = live && !full && !swap_pending && !clear_busy;
  assign push = wr.wr_valid && wr.wr_ready;
  assign pop  = (sel == SEL_FIFO);

  fb_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({wr.wr_addr, wr.wr_data}),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  always_comb begin
    sel = SEL_IDLE;
    unique case (1'b1)
      disp_rd_en:                          sel = SEL_READ;
      (!disp_rd_en && !empty):             sel = SEL_FIFO;
      (!disp_rd_en && empty && clr_active): sel = SEL_CLEAR;
      default:                             sel = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      unique case (sel)
        SEL_READ: begin
          ram_addr <= {front_bank, disp_rd_addr};
          ram_we   <= 1'b0;
        end
        SEL_FIFO: begin
          ram_addr  <= {~front_bank, head[FW-1 -: ADDR_W]};
          ram_we    <= 1'b1;
          ram_wdata <= head[PIXEL_W-1:0];
        end
        SEL_CLEAR: begin
          ram_addr  <= {~front_bank, clr_cnt};
          ram_we    <= 1'b1;
          ram_wdata <= clr_data;
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q1            <= 1'b0;
      rd_q2            <= 1'b0;
      disp_color_valid <= 1'b0;
      disp_color       <= '0;
    end else begin
      rd_q1            <= disp_rd_en;
      rd_q2            <= rd_q1;
      disp_color_valid <= rd_q2;
      if (rd_q2) disp_color <= ram_rdata;
    end
  end

  // a write still in the RAM register stage also blocks the swap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      swap_pending <= 1'b0;
      front_bank   <= 1'b0;
      live         <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        RUN: begin
          if (swap_req && !clear_busy) begin
            state        <= SWAP_WAIT;
            swap_pending <= 1'b1;
          end
        end
        SWAP_WAIT: begin
          if (disp_frame_start && empty && !ram_we) begin
            state        <= RUN;
            swap_pending <= 1'b0;
            front_bank   <= ~front_bank;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FRAME_PIXELS - 1);

  logic clr_go;

  // a same-cycle swap_req wins over clear_req
  assign clr_go = clear_req && !clear_busy && empty &&
                  (state == RUN) && !swap_req;
  assign clr_active = clear_busy;
  assign clr_data   = PIXEL_W'(CLEAR_COLOR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_busy <= 1'b0;
      clr_cnt    <= '0;
    end else if (clr_go) begin
      clear_busy <= 1'b1;
      clr_cnt    <= '0;
    end else if (sel == SEL_CLEAR) begin
      if (clr_cnt == CLR_LAST) clear_busy <= 1'b0;
      else                     clr_cnt    <= clr_cnt + 1'b1;
    end
  end
`else
  logic unused_clear;

  assign clear_busy = 1'b0;
  assign clr_active = 1'b0;
  assign clr_cnt    = '0;
  assign clr_data   = '0;
  assign unused_clear = clear_req ^ (^ADDR_W'(FRAME_PIXELS)) ^
                        (^PIXEL_W'(CLEAR_COLOR));
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a synchronous RAM model.
// Build with +define+FRAME_BUFFER_CLEAR_EN to exercise the full clear.
module tb_frame_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        swap_req;
  logic        swap_pending;
  logic        front_bank;
  logic        clear_req;
  logic        clear_busy;
  logic        disp_frame_start;
  logic        disp_rd_en;
  logic [17:0] disp_rd_addr;
  logic [3:0]  disp_color;
  logic        disp_color_valid;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem [0:(1<<19)-1];

  frame_buffer_arbiter_if #(.ADDR_W(18), .PIXEL_W(4)) wr_if ();

  frame_buffer_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr               (wr_if.slave),
    .swap_req         (swap_req),
    .swap_pending     (swap_pending),
    .front_bank       (front_bank),
    .clear_req        (clear_req),
    .clear_busy       (clear_busy),
    .disp_frame_start (disp_frame_start),
    .disp_rd_en       (disp_rd_en),
    .disp_rd_addr     (disp_rd_addr),
    .disp_color       (disp_color),
    .disp_color_valid (disp_color_valid),
    .ram_addr         (ram_addr),
    .ram_we           (ram_we),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) mem[19'h5] <= 4'hA;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    swap_req = 1'b0;
    clear_req = 1'b0;
    disp_frame_start = 1'b0;
    disp_rd_en = 1'b0;
    disp_rd_addr = '0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;
    #2;
    total++;
    if ({ram_addr, ram_we, ram_wdata, disp_color, disp_color_valid,
         swap_pending, front_bank, clear_busy, wr_if.wr_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h we=%b wd=%h col=%h v=%b sp=%b fb=%b cb=%b rdy=%b want all 0",
               ram_addr, ram_we, ram_wdata, disp_color, disp_color_valid,
               swap_pending, front_bank, clear_busy, wr_if.wr_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", wr_if.wr_ready);
    end
  endtask

  task automatic test_read;
    disp_rd_en = 1'b1;
    disp_rd_addr = 18'd5;
    tick();
    disp_rd_en = 1'b0;
    total++;
    if (ram_addr !== 19'h00005 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL read_addr: got addr=%h we=%b want 00005 0", ram_addr, ram_we);
    end
    tick();
    total++;
    if (disp_color_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_early_valid: got %b want 0", disp_color_valid);
    end
    tick();
    total++;
    if (disp_color_valid !== 1'b1 || disp_color !== 4'hA) begin
      bad++;
      $display("FAIL read_data: got v=%b col=%h want 1 a", disp_color_valid, disp_color);
    end
    tick();
    total++;
    if (disp_color_valid !== 1'b0 || disp_color !== 4'hA) begin
      bad++;
      $display("FAIL read_hold: got v=%b col=%h want 0 a", disp_color_valid, disp_color);
    end
  endtask

  task automatic test_write_blocked;
    int we_seen;
    we_seen = 0;
    disp_rd_en = 1'b1;
    disp_rd_addr = '0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 18'd7;
    wr_if.wr_data = 4'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      wr_if.wr_valid = 1'b0;
      if (ram_we) we_seen++;
    end
    total++;
    if (we_seen != 0) begin
      bad++;
      $display("FAIL write_blocked: got %0d writes want 0", we_seen);
    end
    disp_rd_en = 1'b0;
    tick();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 19'h40007 || ram_wdata !== 4'd3) begin
      bad++;
      $display("FAIL write_issue: got we=%b addr=%h wd=%h want 1 40007 3",
               ram_we, ram_addr, ram_wdata);
    end
    tick();
    total++;
    if (ram_we !== 1'b0 || ram_addr !== 19'h40007) begin
      bad++;
      $display("FAIL idle_hold: got we=%b addr=%h want 0 40007", ram_we, ram_addr);
    end
  endtask

  task automatic test_fifo_full;
    int not_ready;
    int writes;
    not_ready = 0;
    writes = 0;
    disp_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (wr_if.wr_ready !== 1'b1) not_ready++;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr = 18'(i);
      wr_if.wr_data = 4'(i);
      tick();
    end
    wr_if.wr_valid = 1'b0;
    total++;
    if (not_ready != 0 || wr_if.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL fifo_full: got stalls=%0d rdy=%b want 0 0", not_ready, wr_if.wr_ready);
    end
    disp_rd_en = 1'b0;
    tick();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 19'h40000 || wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL fifo_first_drain: got we=%b addr=%h rdy=%b want 1 40000 1",
               ram_we, ram_addr, wr_if.wr_ready);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      if (ram_we && ram_addr == {1'b1, 18'(i)} && ram_wdata == 4'(i)) writes++;
    end
    tick();
    total++;
    if (writes != 15 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL fifo_drain: got %0d ordered writes we=%b want 15 0", writes, ram_we);
    end
  endtask

  task automatic test_swap_deferred;
    int bank1_writes;
    bank1_writes = 0;
    disp_rd_en = 1'b1;
    disp_rd_addr = '0;
    for (int i = 0; i < 3; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr = 18'(100 + i);
      wr_if.wr_data = 4'(9 + i);
      tick();
    end
    wr_if.wr_valid = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    total++;
    if (swap_pending !== 1'b1 || wr_if.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL swap_pending: got sp=%b rdy=%b want 1 0", swap_pending, wr_if.wr_ready);
    end
    tick();
    disp_frame_start = 1'b1;
    tick();
    disp_frame_start = 1'b0;
    total++;
    if (front_bank !== 1'b0 || swap_pending !== 1'b1) begin
      bad++;
      $display("FAIL swap_deferred: got fb=%b sp=%b want 0 1", front_bank, swap_pending);
    end
    disp_rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ram_we && ram_addr[18]) bank1_writes++;
    end
    tick();
    total++;
    if (bank1_writes != 3 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL swap_drain: got %0d bank1 writes we=%b want 3 0", bank1_writes, ram_we);
    end
    disp_frame_start = 1'b1;
    tick();
    disp_frame_start = 1'b0;
    total++;
    if (front_bank !== 1'b1 || swap_pending !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL swap_done: got fb=%b sp=%b rdy=%b want 1 0 1",
               front_bank, swap_pending, wr_if.wr_ready);
    end
    disp_rd_en = 1'b1;
    disp_rd_addr = 18'd5;
    tick();
    disp_rd_en = 1'b0;
    total++;
    if (ram_addr !== 19'h40005) begin
      bad++;
      $display("FAIL swap_read_bank: got %h want 40005", ram_addr);
    end
  endtask

  task automatic test_reset_mid;
    int we_seen;
    we_seen = 0;
    disp_rd_en = 1'b1;
    disp_rd_addr = '0;
    for (int i = 0; i < 5; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr = 18'(200 + i);
      wr_if.wr_data = 4'(i);
      tick();
    end
    wr_if.wr_valid = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    disp_rd_en = 1'b0;
    total++;
    if (swap_pending !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending: got %b want 1", swap_pending);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (swap_pending !== 1'b0 || front_bank !== 1'b0 ||
        ram_we !== 1'b0 || wr_if.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got sp=%b fb=%b we=%b rdy=%b want 0 0 0 0",
               swap_pending, front_bank, ram_we, wr_if.wr_ready);
    end
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ram_we) we_seen++;
    end
    total++;
    if (we_seen != 0 || front_bank !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_release: got writes=%0d fb=%b rdy=%b want 0 0 1",
               we_seen, front_bank, wr_if.wr_ready);
    end
  endtask

`ifdef FRAME_BUFFER_CLEAR_EN
  task automatic test_clear;
    int writes;
    int errs;
    bit done;
    writes = 0;
    errs = 0;
    done = 1'b0;
    disp_rd_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    total++;
    if (clear_busy !== 1'b1 || wr_if.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_start: got cb=%b rdy=%b want 1 0", clear_busy, wr_if.wr_ready);
    end
    for (int i = 0; i < 300000 && !done; i++) begin
      tick();
      if (ram_we) begin
        if (ram_addr !== {1'b1, 18'(writes)} || ram_wdata !== 4'd0) errs++;
        writes++;
      end
      if (!clear_busy) done = 1'b1;
      else if (wr_if.wr_ready !== 1'b0) errs++;
    end
    total++;
    if (!done || writes != 256000 || errs != 0) begin
      bad++;
      $display("FAIL clear_run: got done=%b writes=%0d errs=%0d want 1 256000 0",
               done, writes, errs);
    end
    tick();
    total++;
    if (ram_we !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_end: got we=%b rdy=%b want 0 1", ram_we, wr_if.wr_ready);
    end
  endtask
`else
  task automatic test_clear;
    int busy_seen;
    busy_seen = 0;
    disp_rd_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (clear_busy !== 1'b0 || ram_we !== 1'b0) busy_seen++;
      tick();
    end
    total++;
    if (busy_seen != 0) begin
      bad++;
      $display("FAIL clear_ignored: got %0d busy/write cycles want 0", busy_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_blocked();
    test_fifo_full();
    test_swap_deferred();
    test_reset_mid();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Shares one single-port frame-buffer RAM between the display scan-out (read) and a host pixel writer (write).
- The RAM holds two banks, selected by the address MSB. The display reads the front bank; the host writes the back bank.
- Host writes are buffered in a small FIFO and drained only in cycles the display does not read.
- A host-requested bank swap takes effect at a frame boundary, once all buffered writes have landed.

Parameters:
ADDR_W, 18, pixel address width per bank
PIXEL_W, 4, pixel colour index width
FIFO_DEPTH, 16, host write FIFO entries; must be a power of two
FRAME_PIXELS, 256000, active pixels per frame (640x400)
CLEAR_COLOR, 0, fill value for the optional clear

Ports:
clk  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
wr_valid  input  1  host write request
wr_ready  output  1  write accepted when wr_valid&&wr_ready
wr_addr  input  ADDR_W  host pixel address
wr_data  input  PIXEL_W  host pixel value
swap_req  input  1  single-cycle pulse: request bank swap
swap_pending  output  1  swap requested, not yet performed
front_bank  output  1  bank currently scanned out
clear_req  input  1  single-cycle pulse: clear back bank (optional feature)
clear_busy  output  1  clear in progress
disp_frame_start  input  1  single-cycle pulse at vsync line 0
disp_rd_en  input  1  display read this cycle
disp_rd_addr  input  ADDR_W  display pixel address
disp_color  output  PIXEL_W  read data
disp_color_valid  output  1  disp_color carries a fresh read
ram_addr  output  ADDR_W+1  {bank, addr}
ram_we  output  1  write strobe
ram_wdata  output  PIXEL_W  write data
ram_rdata  input  PIXEL_W  RAM read data, valid one cycle after address

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is reset_n.
- Reset values: all outputs 0, FIFO empty, front_bank=0, no pending swap or clear. Asserting reset mid-operation drops the FIFO contents and any pending swap or clear.
- The RAM port registers are ram_addr, ram_we and ram_wdata. Each cycle they are loaded with exactly one of the following, in priority order:
  1. Display read, if disp_rd_en: {front_bank, disp_rd_addr}, we=0.
  2. FIFO head, if non-empty: {~front_bank, addr}, we=1, pop.
  3. Clear write (optional feature).
  4. Idle: we=0, address held.
- Display read latency: disp_rd_en sampled at cycle N gives disp_color_valid=1 at N+2. disp_color=ram_rdata is registered at N+2. disp_color holds its value when not valid.
- Display reads never stall.
- FIFO: wr_ready = !full && !swap_pending && !clear_busy, computed from registered state only.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- The write address is not range-checked.
- Swap control states: RUN and SWAP_WAIT.
  - RUN → SWAP_WAIT on swap_req. swap_pending=1.
  - SWAP_WAIT → RUN on disp_frame_start when the FIFO is empty and no write is in the RAM register stage. On that edge front_bank toggles and swap_pending clears.
  - If the FIFO is non-empty at disp_frame_start, the swap is deferred to the next frame_start.
  - swap_req while in SWAP_WAIT or while clear_busy is ignored.
- A swap_req and an accepted write in the same cycle: the write belongs to the pre-swap back bank.
- front_bank never changes mid-frame.

Optional Feature:
Macro FRAME_BUFFER_CLEAR_EN.
- Defined:
  - clear_req is accepted only when the FIFO is empty and in RUN state; it sets clear_busy=1.
  - A counter writes CLEAR_COLOR to back-bank addresses 0..FRAME_PIXELS-1, one per free slot (priority 3). The counter advances only when a clear write is issued.
  - clear_busy drops the cycle after the write to FRAME_PIXELS-1 is issued.
  - clear_req while busy is ignored.
- Undefined: the clear_req port exists but is ignored, and clear_busy is tied to 0.

Decomposition:
- Package frame_buffer_pkg holds:
  - swap state enum (RUN, SWAP_WAIT);
  - RAM port-select enum (SEL_READ, SEL_FIFO, SEL_CLEAR, SEL_IDLE);
  - localparams for 640x400 geometry and default PIXEL_W.
- Sub-module fb_write_fifo: a synchronous FIFO parameterised by DEPTH and WIDTH=ADDR_W+PIXEL_W, with ports push, pop, full, empty, head.

Test Plan:
- Reset, then disp_rd_en pulse with disp_rd_addr=5 → ram_addr=0x00005, ram_we=0 next cycle; disp_color=preloaded value, disp_color_valid at +2.
- Write addr=7 data=3 with disp_rd_en held high for 20 cycles → no ram_we during those cycles; write issues the first cycle disp_rd_en=0 with ram_addr={1,7}.
- Push 16 writes during continuous reads → wr_ready=0 after the 16th; the first idle cycle gives ram_we=1 and wr_ready=1 the following cycle.
- swap_req with 3 FIFO entries, frame_start two cycles later → swap deferred; next frame_start after drain → front_bank=1, swap_pending=0, wr_ready=1.
- reset_n low while FIFO holds 5 entries and a swap is pending → immediate clear; no ram_we after release; front_bank=0.
- (FRAME_BUFFER_CLEAR_EN) clear_req with no reads → exactly 256000 writes of 0 to bank 1, clear_busy high throughout; wr_ready=0 throughout.
